// File: rtl/sigma_defs.sv
// Shared definitions for the sigma accumulator readout path: sum width,
// default header nibble, transmitter FSM encodings and the first-byte builder.
package sigma_defs;
  localparam int         SUM_W       = 12;
  localparam logic [3:0] HDR_DEFAULT = 4'hA;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_STOP   = 3'd3,
    S_PARITY = 3'd4
  } tx_state_e;

  // First byte of a word: header nibble over the top nibble of the sum.
  function automatic logic [7:0] hdr_byte(input logic [3:0] hdr, input logic [3:0] hi);
    return {hdr, hi};
  endfunction
endpackage

// File: rtl/sigma_uart_tx_if.sv
// Sum strobe input and serial/status outputs of the sigma UART transmitter.
interface sigma_uart_tx_if;
  import sigma_defs::*;
  logic [SUM_W-1:0] data_in;
  logic             syn_in;
  logic             tx;
  logic             busy;
  logic             ovf;

  modport master (output data_in, syn_in, input tx, busy, ovf);
  modport slave  (input data_in, syn_in, output tx, busy, ovf);
endinterface

// File: rtl/sigma_fifo.sv
// Small synchronous FIFO holding captured sums; head word readable from
// storage registers the cycle after it is written.
module sigma_fifo
  import sigma_defs::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = SUM_W
) (
  input  logic         clk,
  input  logic         res,
  input  logic         i_push,
  input  logic         i_pop,
  input  logic [W-1:0] i_wdata,
  output logic [W-1:0] o_rdata,
  output logic         o_full,
  output logic         o_empty
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr;
  logic [AW-1:0] r_rd;
  logic [AW:0]   r_cnt;
  logic          w_do_pop;
  logic          w_do_push;

  assign o_full    = (r_cnt == (AW+1)'(DEPTH));
  assign o_empty   = (r_cnt == '0);
  assign o_rdata   = r_mem[r_rd];
  assign w_do_pop  = i_pop && !o_empty;
  // A full FIFO still takes a push when the head leaves on the same edge.
  assign w_do_push = i_push && (!o_full || w_do_pop);

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr] <= i_wdata;
  end

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_do_push) r_wr <= r_wr + AW'(1);
      if (w_do_pop)  r_rd <= r_rd + AW'(1);
      r_cnt <= r_cnt + (AW+1)'(w_do_push) - (AW+1)'(w_do_pop);
    end
  end
endmodule

// File: rtl/sigma_uart_tx.sv
// Queues accumulator sums and sends each as two UART bytes ({HDR,d[11:8]}, d[7:0]).
// Define SIGMA_TX_PARITY_EN to add an even-parity bit to every byte.
module sigma_uart_tx
  import sigma_defs::*;
#(
  parameter int         BAUD_DIV = 8,
  parameter int         DEPTH    = 4,
  parameter logic [3:0] HDR      = HDR_DEFAULT
) (
  input  logic            clk,
  input  logic            res,
  sigma_uart_tx_if.slave  bus
);
  localparam int          BW       = $clog2(BAUD_DIV);
  localparam logic [BW-1:0] BAUD_MAX = BW'(BAUD_DIV - 1);

  tx_state_e        r_state, w_state_nx;
  logic [BW-1:0]    r_baud, w_baud_nx;
  logic [2:0]       r_bit, w_bit_nx;
  logic             r_sel, w_sel_nx;
  logic [7:0]       r_shift, w_shift_nx;
  logic [7:0]       r_lo, w_lo_nx;
  logic             r_tx, w_tx_nx;
  logic             r_busy, w_busy_nx;
  logic             r_ovf;
  logic             w_pop, w_full, w_empty, w_baud_end;
  logic [SUM_W-1:0] w_rdata;
`ifdef SIGMA_TX_PARITY_EN
  logic             r_par, w_par_nx;
`endif

  sigma_fifo #(.DEPTH(DEPTH), .W(SUM_W)) u_fifo (
    .clk     (clk),
    .res     (res),
    .i_push  (bus.syn_in),
    .i_pop   (w_pop),
    .i_wdata (bus.data_in),
    .o_rdata (w_rdata),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign w_baud_end = (r_baud == BAUD_MAX);
  assign bus.tx     = r_tx;
  assign bus.busy   = r_busy;
  assign bus.ovf    = r_ovf;

  always_comb begin
    w_state_nx = r_state;
    w_baud_nx  = r_baud + BW'(1);
    w_bit_nx   = r_bit;
    w_sel_nx   = r_sel;
    w_shift_nx = r_shift;
    w_lo_nx    = r_lo;
    w_tx_nx    = r_tx;
    w_busy_nx  = r_busy;
    w_pop      = 1'b0;
`ifdef SIGMA_TX_PARITY_EN
    w_par_nx   = r_par;
`endif
    case (r_state)
      S_IDLE: begin
        w_baud_nx = '0;
        if (!w_empty) begin
          w_pop      = 1'b1;
          w_shift_nx = hdr_byte(HDR, w_rdata[11:8]);
          w_lo_nx    = w_rdata[7:0];
          w_sel_nx   = 1'b0;
          w_tx_nx    = 1'b0;
          w_busy_nx  = 1'b1;
          w_state_nx = S_START;
`ifdef SIGMA_TX_PARITY_EN
          w_par_nx   = ^hdr_byte(HDR, w_rdata[11:8]);
`endif
        end
      end
      S_START: if (w_baud_end) begin
        w_baud_nx  = '0;
        w_bit_nx   = '0;
        w_tx_nx    = r_shift[0];
        w_shift_nx = r_shift >> 1;
        w_state_nx = S_DATA;
      end
      S_DATA: if (w_baud_end) begin
        w_baud_nx = '0;
        if (r_bit == 3'd7) begin
`ifdef SIGMA_TX_PARITY_EN
          w_tx_nx    = r_par;
          w_state_nx = S_PARITY;
`else
          w_tx_nx    = 1'b1;
          w_state_nx = S_STOP;
`endif
        end else begin
          w_bit_nx   = r_bit + 3'd1;
          w_tx_nx    = r_shift[0];
          w_shift_nx = r_shift >> 1;
        end
      end
`ifdef SIGMA_TX_PARITY_EN
      S_PARITY: if (w_baud_end) begin
        w_baud_nx  = '0;
        w_tx_nx    = 1'b1;
        w_state_nx = S_STOP;
      end
`endif
      S_STOP: if (w_baud_end) begin
        w_baud_nx = '0;
        // Second byte follows the first stop bit back-to-back.
        if (!r_sel) begin
          w_shift_nx = r_lo;
          w_sel_nx   = 1'b1;
          w_tx_nx    = 1'b0;
          w_state_nx = S_START;
`ifdef SIGMA_TX_PARITY_EN
          w_par_nx   = ^r_lo;
`endif
        end else begin
          w_busy_nx  = 1'b0;
          w_state_nx = S_IDLE;
        end
      end
      default: begin
        w_baud_nx  = '0;
        w_state_nx = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      r_state <= S_IDLE;
      r_baud  <= '0;
      r_bit   <= '0;
      r_sel   <= 1'b0;
      r_shift <= '0;
      r_lo    <= '0;
      r_tx    <= 1'b1;
      r_busy  <= 1'b0;
      r_ovf   <= 1'b0;
`ifdef SIGMA_TX_PARITY_EN
      r_par   <= 1'b0;
`endif
    end else begin
      r_state <= w_state_nx;
      r_baud  <= w_baud_nx;
      r_bit   <= w_bit_nx;
      r_sel   <= w_sel_nx;
      r_shift <= w_shift_nx;
      r_lo    <= w_lo_nx;
      r_tx    <= w_tx_nx;
      r_busy  <= w_busy_nx;
      r_ovf   <= bus.syn_in && w_full && !w_pop;
`ifdef SIGMA_TX_PARITY_EN
      r_par   <= w_par_nx;
`endif
    end
  end
endmodule

// File: doc/sigma_uart_tx.md
Name: sigma_uart_tx

Overview:
- Downstream stage of the 16-sample accumulator.
- Captures each 12-bit two's-complement sum on its one-cycle sync pulse and queues it in a small FIFO.
- Serializes each sum as a two-byte 8N1 UART frame pair on a single tx line for host/logic-analyser readout.
- Decouples the slow accumulation rate from the serial line and flags dropped sums.

Parameters:
- BAUD_DIV, 8, clocks per UART bit (≥2); small default for simulation speed.
- DEPTH, 4, FIFO entries (power of 2, ≥2).
- HDR, 4'hA, nibble placed in bits [7:4] of the first byte of each word.

Ports:
- clk  input  1  system clock, rising edge.
- res  input  1  asynchronous, active-high reset.
- data_in  input  12  accumulated sum, two's complement; valid when syn_in=1.
- syn_in  input  1  one-cycle strobe from the accumulator (its syn_out).
- tx  output  1  UART serial out, idle high.
- busy  output  1  high while a word is being transmitted.
- ovf  output  1  one-cycle pulse when a word is dropped because the FIFO is full.

Behaviour:
- Reset (async, res=1) applies immediately, including mid-frame:
  - tx=1, busy=0, ovf=0.
  - FIFO emptied (pointers and count 0).
  - FSM=IDLE, baud counter, bit counter and byte select all 0.
- Push: on a rising edge with syn_in=1, data_in is written to the FIFO.
  - If the FIFO is full and no pop occurs that same edge, the word is dropped and ovf=1 for exactly the next cycle.
  - Push and pop on the same edge are both honoured; a full FIFO with a simultaneous pop accepts the push.
- Frame format: 2 bytes per word, each sent LSB first.
  - byte0 = {HDR, d[11:8]}.
  - byte1 = d[7:0].
  - Each byte: start bit (0), 8 data bits, stop bit (1); every bit lasts exactly BAUD_DIV cycles.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: if FIFO not empty, pop on this edge, load shift register with byte0, set byte_sel=0, tx<=0, busy<=1, go START.
  - START: after BAUD_DIV cycles go DATA.
  - DATA: shift out 8 bits, BAUD_DIV cycles each, then tx<=1 and go STOP.
  - STOP: after BAUD_DIV cycles:
    - if byte_sel=0: load byte1, byte_sel<=1, tx<=0, go START (no gap between bytes);
    - otherwise go IDLE and set busy<=0.
- Latency:
  - Push at edge E0 into an empty FIFO with FSM in IDLE → pop at E1, tx low from E1.
  - Word duration = 20×BAUD_DIV cycles.
  - Exactly one IDLE cycle between consecutive words (busy low for that cycle).
- tx, busy and ovf are registered (glitch-free).
- data_in is held in the FIFO unmodified; no sign handling is needed because bytes carry the raw bits.

Optional Feature:
- Macro: SIGMA_TX_PARITY_EN.
- Defined:
  - a PARITY state is inserted between DATA and STOP;
  - it transmits an even-parity bit (XOR of the 8 data bits) for BAUD_DIV cycles;
  - each byte becomes 11 bits and a word takes 22×BAUD_DIV cycles.
- Undefined: 8N1 exactly as above; no PARITY state or logic is present.

Decomposition:
- Shared package/header sigma_defs holds:
  - FSM state encodings (IDLE=0, START=1, DATA=2, STOP=3, PARITY=4);
  - the HDR default;
  - the 12-bit sum width constant shared with the accumulator.
- One sub-module, sigma_fifo:
  - synchronous FIFO, width 12, DEPTH entries;
  - ports: push, pop, wdata, rdata, full, empty;
  - async active-high reset;
  - first-word read data available the cycle after the push (registered).
- The FSM and baud counter stay in the top level.

Test Plan:
- Reset then idle: hold res=1 for 17 ns, release, no syn_in for 1000 cycles → tx=1, busy=0, ovf=0 throughout.
- Single word, BAUD_DIV=8: syn_in pulse with data_in=12'h5A3 → tx low at E1; decoded bytes 0xA5 then 0xA3; busy high for 160 cycles, then 0.
- Negative sum: data_in=12'hFF0 (−16) → bytes 0xAF, 0xF0.
- Overflow, DEPTH=4: six syn_in pulses on consecutive cycles with words 1..6 →
  - w1 popped at E1, w2–w5 fill the FIFO;
  - w6 dropped with one ovf pulse the cycle after E5;
  - words 1–5 transmitted in order, one idle cycle between each.
- Reset mid-frame: assert res during DATA of byte0 → tx=1 and busy=0 immediately; after release no residual word is transmitted.
- With SIGMA_TX_PARITY_EN defined, data_in=12'h007 → byte0 0xA0 has parity bit 0, byte1 0x07 has parity bit 1; word takes 176 cycles.
